uv_line_buffer: RTL and testbench

Double-buffered, parametrised UV line buffer between the rasteriser's UV writer and the pixel shader, replacing the fixed-pattern UV stub. The writer fills one bank while the shader reads the other. Banks swap on the shader's line-start pulse. Underruns are counted, and reads without a valid line return zero or, optionally, a synthetic test pattern.

---
 rtl/uv_buf_pkg.sv | 28 ++
 rtl/uv_bank_ram.sv | 30 +++
 rtl/uv_line_buffer.sv | 161 ++++++++++++++++
 tb/tb_uv_line_buffer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uv_buf_pkg.sv
// Shared types and defaults for the double-buffered UV line buffer.
// Holds the bank-state encoding, the default geometry and the test-pattern field layout.
package uv_buf_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bank_state_t;

  localparam int UV_DATA_W_DEF = 32;
  localparam int UV_ADDR_W_DEF = 11;
  localparam int UV_DEPTH_DEF  = 1280;
  localparam int UV_LINE_W_DEF = 10;

  localparam int PAT_LINE_W = 12;
  localparam int PAT_ADDR_W = 12;
  localparam int PAT_LOW_W  = 8;
  localparam int PAT_W      = PAT_LINE_W + PAT_ADDR_W + PAT_LOW_W;

  // Gradient: inverted scanline on top, address in the middle, inverted coarse address below.
  function automatic logic [PAT_W-1:0] uv_pattern(input logic [8:0] line9,
                                                  input logic [8:0] addr9);
    return {~line9, 3'b000, addr9, 3'b000, ~addr9[8:1]};
  endfunction

endpackage

// File: rtl/uv_bank_ram.sv
// One line bank: simple dual-port RAM, synchronous write, 1-cycle registered read.
// The read register only updates on rd_en, so the last word read is held.
module uv_bank_ram
  import uv_buf_pkg::*;
#(
  parameter int DATA_W = UV_DATA_W_DEF,
  parameter int ADDR_W = UV_ADDR_W_DEF,
  parameter int DEPTH  = UV_DEPTH_DEF
) (
  input  logic              clk100,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk100) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/uv_line_buffer.sv
// Double-buffered UV line store: the writer fills one bank while the shader reads the other.
// Define UV_TEST_PATTERN_EN to return a synthetic gradient (instead of zero) on reads without a line.
module uv_line_buffer
  import uv_buf_pkg::*;
#(
  parameter int DATA_W = UV_DATA_W_DEF,
  parameter int ADDR_W = UV_ADDR_W_DEF,
  parameter int DEPTH  = UV_DEPTH_DEF,
  parameter int LINE_W = UV_LINE_W_DEF
) (
  input  logic              clk100,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  input  logic              line_start,
  input  logic [LINE_W-1:0] Line,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] Shader_UV_Addr,
  output logic [DATA_W-1:0] UV_Shader_Data,
  output logic              rd_valid,
  output logic [15:0]       underrun_cnt
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  bank_state_t       bank_st   [2];
  bank_state_t       bank_st_n [2];
  logic              wb, wb_n;
  logic              rb, rb_n;
  logic              rbv, rbv_n;
  logic [15:0]       cnt_n;
  logic              wr_accept, wr_done, wr_in_range;
  logic              rd_in_range, rd_hit;
  logic [DATA_W-1:0] ram_q [2];
  logic [DATA_W-1:0] fallback, fb_q;
  logic              src_ram, src_bank;
  logic              unused_line;

  assign wr_accept   = wr_valid && wr_ready;
  assign wr_done     = wr_accept && wr_last;
  assign wr_in_range = {1'b0, wr_addr} < DEPTH_L;
  assign rd_in_range = {1'b0, Shader_UV_Addr} < DEPTH_L;
  assign rd_hit      = rd_en && rbv && rd_in_range;
  assign unused_line = ^Line;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    uv_bank_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
    ) u_ram (
      .clk100  (clk100),
      .we      (wr_accept && wr_in_range && (wb == 1'(b))),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (rd_hit && (rb == 1'(b))),
      .rd_addr (Shader_UV_Addr),
      .rd_data (ram_q[b])
    );
  end

`ifdef UV_TEST_PATTERN_EN
  logic [PAT_W-1:0] pat_full;
  assign pat_full = uv_pattern(Line[8:0], Shader_UV_Addr[8:0]);
  if (DATA_W == PAT_W) begin : g_pat_eq
    assign fallback = pat_full;
  end else if (DATA_W > PAT_W) begin : g_pat_wide
    assign fallback = {{(DATA_W-PAT_W){1'b0}}, pat_full};
  end else begin : g_pat_narrow
    assign fallback = pat_full[PAT_W-1 -: DATA_W];
  end
`else
  assign fallback = '0;
`endif

  // Completion is applied before the swap so a line finished in the same cycle as
  // line_start can be read straight away; the refill pass then restores one FILLING bank.
  always_comb begin
    bank_st_n = bank_st;
    wb_n      = wb;
    rb_n      = rb;
    rbv_n     = rbv;
    cnt_n     = underrun_cnt;
    if (wr_done) begin
      bank_st_n[wb] = BANK_FULL;
    end
    if (line_start) begin
      for (int i = 0; i < 2; i++) begin
        if (bank_st_n[i] == BANK_READING) begin
          bank_st_n[i] = BANK_EMPTY;
        end
      end
      if (bank_st_n[~wb] == BANK_FULL) begin
        bank_st_n[~wb] = BANK_READING;
        rb_n           = ~wb;
        rbv_n          = 1'b1;
      end else if (bank_st_n[wb] == BANK_FULL) begin
        bank_st_n[wb] = BANK_READING;
        rb_n          = wb;
        rbv_n         = 1'b1;
      end else begin
        rbv_n = 1'b0;
        if (underrun_cnt != 16'hFFFF) begin
          cnt_n = underrun_cnt + 16'd1;
        end
      end
    end
    if ((bank_st_n[0] != BANK_FILLING) && (bank_st_n[1] != BANK_FILLING)) begin
      if (bank_st_n[~wb] == BANK_EMPTY) begin
        bank_st_n[~wb] = BANK_FILLING;
        wb_n           = ~wb;
      end else if (bank_st_n[wb] == BANK_EMPTY) begin
        bank_st_n[wb] = BANK_FILLING;
      end
    end
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      bank_st[0]   <= BANK_FILLING;
      bank_st[1]   <= BANK_EMPTY;
      wb           <= 1'b0;
      rb           <= 1'b0;
      rbv          <= 1'b0;
      underrun_cnt <= 16'd0;
      wr_ready     <= 1'b1;
    end else begin
      bank_st      <= bank_st_n;
      wb           <= wb_n;
      rb           <= rb_n;
      rbv          <= rbv_n;
      underrun_cnt <= cnt_n;
      wr_ready     <= (bank_st_n[0] == BANK_FILLING) || (bank_st_n[1] == BANK_FILLING);
    end
  end

  // Read source is latched with the address so held data stays consistent while rd_en is low.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      src_ram  <= 1'b0;
      src_bank <= 1'b0;
      fb_q     <= '0;
    end else begin
      rd_valid <= rd_hit;
      if (rd_en) begin
        src_ram <= rd_hit;
        fb_q    <= fallback;
        if (rd_hit) begin
          src_bank <= rb;
        end
      end
    end
  end

  assign UV_Shader_Data = src_ram ? ram_q[src_bank] : fb_q;

endmodule

// File: tb/tb_uv_line_buffer.sv
// Self-checking bench for uv_line_buffer: directed scenarios plus randomized traffic
// compared every cycle against a line-queue model of the buffer.
module tb_uv_line_buffer;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 1280;
  localparam int LINE_W = 10;

  logic              clk100 = 1'b0;
  logic              rst_n  = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_last = 1'b0;
  logic              line_start = 1'b0;
  logic [LINE_W-1:0] line_in = '0;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [15:0]       underrun_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk100 = ~clk100;

  uv_line_buffer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .LINE_W (LINE_W)
  ) dut (
    .clk100         (clk100),
    .rst_n          (rst_n),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_last        (wr_last),
    .line_start     (line_start),
    .Line           (line_in),
    .rd_en          (rd_en),
    .Shader_UV_Addr (rd_addr),
    .UV_Shader_Data (rd_data),
    .rd_valid       (rd_valid),
    .underrun_cnt   (underrun_cnt)
  );

  // Expected fallback word for a read that has no valid line behind it.
  function automatic logic [31:0] fallbackWord(input logic [LINE_W-1:0] ln, input logic [ADDR_W-1:0] a);
    logic unused_args;
`ifdef UV_TEST_PATTERN_EN
    logic [11:0] hi;
    logic [11:0] mid;
    logic [7:0]  lo;
    unused_args = ^{ln, a};
    hi  = 12'((511 - int'(ln[8:0])) * 8);
    mid = 12'(int'(a[8:0]) * 8);
    lo  = 8'(255 - int'(a[8:1]));
    return {hi, mid, lo};
`else
    unused_args = ^{ln, a};
    return 32'd0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: lines are slots holding words plus a written mask; held lines form a FIFO.
  logic [31:0] m_d [4][DEPTH];
  bit          m_w [4][DEPTH];
  int          full_q[$];
  int          fill_id, read_id, next_id;
  bit          have_read, m_ready, m_valid, m_known;
  logic [31:0] m_data;
  logic [15:0] m_cnt;

  task automatic newFill();
    fill_id = next_id;
    next_id = (next_id + 1) % 4;
    for (int i = 0; i < DEPTH; i++) m_w[fill_id][i] = 1'b0;
  endtask

  task automatic modelReset();
    full_q.delete();
    have_read = 1'b0;
    m_ready   = 1'b1;
    m_valid   = 1'b0;
    m_known   = 1'b1;
    m_data    = 32'd0;
    m_cnt     = 16'd0;
    newFill();
  endtask

  initial begin
    next_id = 0;
    read_id = 0;
    modelReset();
    forever begin
      @(posedge clk100 or negedge rst_n);
      if (!rst_n) begin
        modelReset();
      end else begin
        if (rd_en) begin
          if (have_read && rd_addr < DEPTH) begin
            m_valid = 1'b1;
            m_data  = m_d[read_id][rd_addr];
            m_known = m_w[read_id][rd_addr];
          end else begin
            m_valid = 1'b0;
            m_data  = fallbackWord(line_in, rd_addr);
            m_known = 1'b1;
          end
        end else begin
          m_valid = 1'b0;
        end
        if (wr_valid && m_ready) begin
          if (wr_addr < DEPTH) begin
            m_d[fill_id][wr_addr] = wr_data;
            m_w[fill_id][wr_addr] = 1'b1;
          end
          if (wr_last) begin
            full_q.push_back(fill_id);
            newFill();
          end
        end
        if (line_start) begin
          if (full_q.size() > 0) begin
            read_id   = full_q.pop_front();
            have_read = 1'b1;
          end else begin
            have_read = 1'b0;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          end
        end
        m_ready = (int'(have_read) + full_q.size()) < 2;
      end
    end
  end

  always @(negedge clk100) begin
    if (rst_n) begin
      checkOutput("model wr_ready", 32'(wr_ready), 32'(m_ready));
      checkOutput("model rd_valid", 32'(rd_valid), 32'(m_valid));
      checkOutput("model underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
      if (m_known) checkOutput("model data", rd_data, m_data);
    end
  end

  task automatic applyStimulus(input logic wv, input logic [ADDR_W-1:0] wa, input logic [31:0] wd,
                               input logic wl, input logic ls, input logic re,
                               input logic [ADDR_W-1:0] ra);
    wr_valid   = wv;
    wr_addr    = wa;
    wr_data    = wd;
    wr_last    = wl;
    line_start = ls;
    rd_en      = re;
    rd_addr    = ra;
    @(posedge clk100);
    #2;
    wr_valid   = 1'b0;
    wr_last    = 1'b0;
    line_start = 1'b0;
    rd_en      = 1'b0;
  endtask

  task automatic syncReset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk100);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic asyncResetMidCycle(input bit checkLiterals);
    wr_valid = 1'b1;
    wr_addr  = 11'd3;
    wr_data  = 32'h1234_5678;
    @(posedge clk100);
    #3;
    rst_n = 1'b0;
    #1;
    if (checkLiterals) begin
      checkOutput("async reset wr_ready", 32'(wr_ready), 32'd1);
      checkOutput("async reset rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("async reset data", rd_data, 32'd0);
      checkOutput("async reset underrun_cnt", 32'(underrun_cnt), 32'd0);
    end
    wr_valid = 1'b0;
    @(posedge clk100);
    #2;
    rst_n = 1'b1;
  endtask

  logic [31:0] exp_under;
  logic [ADDR_W-1:0] wa, ra;

  initial begin
    syncReset();
    checkOutput("reset wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("reset rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("reset data", rd_data, 32'd0);
    checkOutput("reset underrun_cnt", 32'(underrun_cnt), 32'd0);

    for (int a = 0; a < DEPTH; a++)
      applyStimulus(1'b1, 11'(a), 32'(a), a == DEPTH - 1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 11'd5);
    checkOutput("fill line data", rd_data, 32'd5);
    checkOutput("fill line rd_valid", 32'(rd_valid), 32'd1);

    for (int a = 0; a < 4; a++)
      applyStimulus(1'b1, 11'(a), 32'(100 + a), a == 3, 1'b0, 1'b0, '0);
    checkOutput("backpressure wr_ready low", 32'(wr_ready), 32'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0);
    checkOutput("backpressure wr_ready high", 32'(wr_ready), 32'd1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 11'd2);
    checkOutput("second line data", rd_data, 32'd102);

    syncReset();
    line_in = '0;
    repeat (3) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0);
    checkOutput("underrun count", 32'(underrun_cnt), 32'd3);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 11'd2);
`ifdef UV_TEST_PATTERN_EN
    exp_under = 32'hFF80_10FE;
`else
    exp_under = 32'h0;
`endif
    checkOutput("underrun rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("underrun data", rd_data, exp_under);

    applyStimulus(1'b1, 11'd7, 32'hCAFE_0007, 1'b1, 1'b1, 1'b0, '0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 11'd7);
    checkOutput("bypass data", rd_data, 32'hCAFE_0007);
    checkOutput("bypass rd_valid", 32'(rd_valid), 32'd1);
    checkOutput("bypass underrun_cnt", 32'(underrun_cnt), 32'd3);

    applyStimulus(1'b1, 11'd1500, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("out of range wr_last blocks", 32'(wr_ready), 32'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 11'd1500);
    checkOutput("out of range rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("out of range underrun_cnt", 32'(underrun_cnt), 32'd3);

    asyncResetMidCycle(1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 11'd3);
    checkOutput("post reset rd_valid", 32'(rd_valid), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      wa = ($urandom_range(0, 15) == 0) ? 11'($urandom_range(DEPTH, 2047)) : 11'($urandom_range(0, 31));
      ra = ($urandom_range(0, 15) == 0) ? 11'($urandom_range(DEPTH, 2047)) : 11'($urandom_range(0, 39));
      line_in = 10'($urandom);
      applyStimulus($urandom_range(0, 3) != 0, wa, $urandom, $urandom_range(0, 24) == 0,
                    $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1, ra);
      if (i == 1500) asyncResetMidCycle(1'b0);
    end

    repeat (2) @(posedge clk100);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
